// File: rtl/spi_mstr.sv
// ---------------------------------------------------------------------------
// spi_mstr -- host-side SPI master, mode 3 (SCLK idles high, data launched on
// the falling edge, sampled on the rising edge). One WIDTH-bit full-duplex
// frame is sent per accepted wrt request, MSB first.
//
// Ports
//   clk      in   1      system clock, all state changes on posedge
//   rst_n    in   1      asynchronous active-low reset
//   wrt      in   1      start request, only looked at while idle
//   cmd      in   WIDTH  frame to transmit, captured when wrt is accepted
//   MISO     in   1      serial data from the slave
//   SS_n     out  1      active-low slave select
//   SCLK     out  1      serial clock, idles high
//   MOSI     out  1      serial data to the slave (MSB of the shift register)
//   done     out  1      frame complete, held until the next accepted wrt
//   rd_data  out  WIDTH  received frame, valid while done is high
// ---------------------------------------------------------------------------
module spi_mstr #(
  parameter int HALF_PER = 8,
  parameter int WIDTH    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt,
  input  logic [WIDTH-1:0] cmd,
  input  logic             MISO,
  output logic             SS_n,
  output logic             SCLK,
  output logic             MOSI,
  output logic             done,
  output logic [WIDTH-1:0] rd_data
);

  localparam int            BW      = $clog2(WIDTH) + 1;
  localparam logic [7:0]    HC_MAX  = 8'(HALF_PER - 1);
  localparam logic [BW-1:0] BC_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    XFER  = 2'd2,
    BACK  = 2'd3
  } state_t;

  state_t           state_r,   state_nxt_s;
  logic [7:0]       hcnt_r,    hcnt_nxt_s;
  logic [BW-1:0]    bcnt_r,    bcnt_nxt_s;
  logic [WIDTH-1:0] shft_r,    shft_nxt_s;
  logic [WIDTH-1:0] rd_data_r, rd_data_nxt_s;
  logic             smpl_r,    smpl_nxt_s;
  logic             ss_n_r,    ss_n_nxt_s;
  logic             sclk_r,    sclk_nxt_s;
  logic             done_r,    done_nxt_s;
  logic             half_end_s;
  logic [WIDTH-1:0] shift_in_s;

  // last clk cycle of the current SCLK half-period
  assign half_end_s = (hcnt_r == HC_MAX);
  // shift register advanced by one bit with the most recent MISO sample
  assign shift_in_s = {shft_r[WIDTH-2:0], smpl_r};

  // Next-state and datapath decode
  always_comb begin
    state_nxt_s   = state_r;
    hcnt_nxt_s    = hcnt_r;
    bcnt_nxt_s    = bcnt_r;
    shft_nxt_s    = shft_r;
    rd_data_nxt_s = rd_data_r;
    smpl_nxt_s    = smpl_r;
    ss_n_nxt_s    = ss_n_r;
    sclk_nxt_s    = sclk_r;
    done_nxt_s    = done_r;

    case (state_r)
      IDLE: begin
        if (wrt) begin
          ss_n_nxt_s  = 1'b0;
          shft_nxt_s  = cmd;
          done_nxt_s  = 1'b0;
          hcnt_nxt_s  = 8'd0;
          bcnt_nxt_s  = {BW{1'b0}};
          state_nxt_s = FRONT;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      // SCLK held high one half-period after SS_n drops; the first fall
      // launches nothing because MOSI already carries cmd's MSB.
      FRONT: begin
        if (half_end_s) begin
          sclk_nxt_s  = 1'b0;
          hcnt_nxt_s  = 8'd0;
          state_nxt_s = XFER;
        end else begin
          hcnt_nxt_s  = hcnt_r + 8'd1;
        end
      end

      XFER: begin
        if (half_end_s) begin
          hcnt_nxt_s = 8'd0;
          sclk_nxt_s = ~sclk_r;
          if (!sclk_r) begin
            // rising edge: capture MISO, count the bit
            smpl_nxt_s = MISO;
            bcnt_nxt_s = bcnt_r + {{(BW-1){1'b0}}, 1'b1};
            if (bcnt_r == BC_LAST) begin
              state_nxt_s = BACK;
            end else begin
              state_nxt_s = XFER;
            end
          end else begin
            // falling edge: launch next MOSI bit, absorb previous sample
            if (bcnt_r != {BW{1'b0}}) begin
              shft_nxt_s = shift_in_s;
            end else begin
              shft_nxt_s = shft_r;
            end
          end
        end else begin
          hcnt_nxt_s = hcnt_r + 8'd1;
        end
      end

      // trailing half-period with SCLK high, then the last sample is
      // shifted in and the frame is closed
      BACK: begin
        if (half_end_s) begin
          shft_nxt_s    = shift_in_s;
          rd_data_nxt_s = shift_in_s;
          ss_n_nxt_s    = 1'b1;
          done_nxt_s    = 1'b1;
          hcnt_nxt_s    = 8'd0;
          bcnt_nxt_s    = {BW{1'b0}};
          state_nxt_s   = IDLE;
        end else begin
          hcnt_nxt_s    = hcnt_r + 8'd1;
        end
      end

      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_r    <= 8'd0;
      bcnt_r    <= {BW{1'b0}};
      shft_r    <= {WIDTH{1'b0}};
      rd_data_r <= {WIDTH{1'b0}};
      smpl_r    <= 1'b0;
      ss_n_r    <= 1'b1;
      sclk_r    <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      hcnt_r    <= hcnt_nxt_s;
      bcnt_r    <= bcnt_nxt_s;
      shft_r    <= shft_nxt_s;
      rd_data_r <= rd_data_nxt_s;
      smpl_r    <= smpl_nxt_s;
      ss_n_r    <= ss_n_nxt_s;
      sclk_r    <= sclk_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  assign SS_n    = ss_n_r;
  assign SCLK    = sclk_r;
  assign MOSI    = shft_r[WIDTH-1];
  assign done    = done_r;
  assign rd_data = rd_data_r;

endmodule

// File: tb/tb_spi_mstr.sv
// ---------------------------------------------------------------------------
// tb_spi_mstr -- directed bench for spi_mstr. A behavioural mode-3 slave
// drives MISO on SCLK falls and records MOSI on SCLK rises. A second
// instance with HALF_PER=2 and MISO tied low covers the minimum half-period.
// ---------------------------------------------------------------------------
module tb_spi_mstr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wrt, wrt2;
  logic [15:0] cmd, cmd2;
  logic        miso;
  logic        ss_n, sclk, mosi, done;
  logic [15:0] rd_data;
  logic        ss_n2, sclk2, mosi2, done2;
  logic [15:0] rd_data2;

  int check_cnt = 0;
  int err_cnt   = 0;

  // slave model state
  logic [15:0] slave_resp;
  logic [15:0] frame_resp;
  logic [15:0] slave_rx;
  int          rise_cnt  = 0;
  int          frame_rc0 = 0;
  int          done_rises = 0;

  always #5 clk = ~clk;

  spi_mstr #(.HALF_PER(8), .WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .wrt(wrt), .cmd(cmd), .MISO(miso),
    .SS_n(ss_n), .SCLK(sclk), .MOSI(mosi), .done(done), .rd_data(rd_data)
  );

  spi_mstr #(.HALF_PER(2), .WIDTH(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wrt(wrt2), .cmd(cmd2), .MISO(1'b0),
    .SS_n(ss_n2), .SCLK(sclk2), .MOSI(mosi2), .done(done2), .rd_data(rd_data2)
  );

  // slave latches its response and the rise count at frame start
  always @(negedge ss_n) begin
    frame_resp = slave_resp;
    frame_rc0  = rise_cnt;
  end

  // slave launches bit (15 - rises so far) on every SCLK fall
  always @(negedge sclk) begin
    if (!ss_n) begin
      int idx;
      idx = rise_cnt - frame_rc0;
      if (idx >= 0 && idx < 16) miso = frame_resp[15 - idx];
    end
  end

  // slave samples MOSI and counts rises
  always @(posedge sclk) begin
    if (!ss_n) begin
      slave_rx = {slave_rx[14:0], mosi};
      rise_cnt = rise_cnt + 1;
    end
  end

  // count done rising edges
  always @(posedge done) done_rises = done_rises + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    check_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // wait (bounded) for SS_n to drop; leaves us #1 after the drop edge
  task automatic wait_drop(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!ss_n) begin seen = 1'b1; break; end
    end
    check_val(tag, {31'd0, seen}, 32'd1);
  endtask

  // count clk edges from the drop edge until SS_n rises; optional wrt/cmd
  // disturbance at cycles 20 and 100 of the frame
  task automatic wait_low(output int n, input bit perturb);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      n++;
      if (perturb) begin
        if (n == 20 || n == 100) begin wrt = 1'b1; cmd = 16'hFFFF; end
        else begin wrt = 1'b0; end
      end
      if (ss_n) break;
    end
  endtask

  // one complete single-shot frame with all frame-level checks
  task automatic run_frame(input string tag, input logic [15:0] c,
                           input logic [15:0] resp, input bit perturb);
    int n;
    slave_resp = resp;
    @(negedge clk);
    cmd = c;
    wrt = 1'b1;
    wait_drop({tag, "_start"});
    wrt = 1'b0;
    check_val({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    wait_low(n, perturb);
    check_val({tag, "_ssn_len"}, n, 32'd264);
    check_val({tag, "_rises"}, rise_cnt - frame_rc0, 32'd16);
    check_val({tag, "_mosi"}, {16'd0, slave_rx}, {16'd0, c});
    check_val({tag, "_rd"}, {16'd0, rd_data}, {16'd0, resp});
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [15:0] cmds  [3];
    logic [15:0] resps [3];
    int          n, d0, bad, r1, r2, nr;
    logic [15:0] rd0;
    logic        prev;

    wrt = 1'b0; wrt2 = 1'b0; cmd = 16'h0000; cmd2 = 16'h0000;
    miso = 1'b0; slave_resp = 16'h0000; slave_rx = 16'h0000;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ssn",  {31'd0, ss_n}, 32'd1);
    check_val("rst_sclk", {31'd0, sclk}, 32'd1);
    check_val("rst_mosi", {31'd0, mosi}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_rd",   {16'd0, rd_data}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: basic frame
    run_frame("t1", 16'hA5C3, 16'h0ABC, 1'b0);

    // 2: wrt pulses and cmd changes mid-frame are ignored
    d0 = done_rises;
    run_frame("t2", 16'h3C96, 16'hBEEF, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check_val("t2_no_restart", {31'd0, ss_n}, 32'd1);
    check_val("t2_one_done", done_rises - d0, 32'd1);

    // 3: wrt held high for three back-to-back frames
    cmds[0] = 16'h1234; cmds[1] = 16'h5678; cmds[2] = 16'h9ABC;
    resps[0] = 16'h0123; resps[1] = 16'h1234; resps[2] = 16'h5678;
    slave_resp = resps[0];
    @(negedge clk);
    cmd = cmds[0];
    wrt = 1'b1;
    wait_drop("t3_start");
    for (int k = 0; k < 3; k++) begin
      wait_low(n, 1'b0);
      check_val($sformatf("t3_len%0d", k), n, 32'd264);
      check_val($sformatf("t3_rd%0d", k), {16'd0, rd_data}, {16'd0, resps[k]});
      check_val($sformatf("t3_mosi%0d", k), {16'd0, slave_rx}, {16'd0, cmds[k]});
      if (k < 2) begin
        cmd = cmds[k+1];
        slave_resp = resps[k+1];
        @(posedge clk); #1;
        check_val($sformatf("t3_gap%0d", k), {31'd0, ss_n}, 32'd0);
      end else begin
        wrt = 1'b0;
      end
    end

    // 4: reset at the 7th SCLK rise
    slave_resp = 16'h7E81;
    @(negedge clk);
    cmd = 16'hC0DE;
    wrt = 1'b1;
    wait_drop("t4_start");
    wrt = 1'b0;
    nr = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      nr = rise_cnt - frame_rc0;
      if (nr == 7) break;
    end
    check_val("t4_reach7", nr, 32'd7);
    rst_n = 1'b0;
    #1;
    check_val("t4_ssn",  {31'd0, ss_n}, 32'd1);
    check_val("t4_sclk", {31'd0, sclk}, 32'd1);
    check_val("t4_mosi", {31'd0, mosi}, 32'd0);
    check_val("t4_done", {31'd0, done}, 32'd0);
    check_val("t4_rd",   {16'd0, rd_data}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_frame("t4b", 16'hA5C3, 16'h0ABC, 1'b0);

    // 5: HALF_PER=2 instance, all-ones command, MISO low
    @(negedge clk);
    cmd2 = 16'hFFFF;
    wrt2 = 1'b1;
    @(posedge clk); #1;
    wrt2 = 1'b0;
    check_val("t5_start", {31'd0, ss_n2}, 32'd0);
    n = 0; r1 = -1; r2 = -1; prev = sclk2;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      n++;
      if (sclk2 && !prev && !ss_n2) begin
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      prev = sclk2;
      if (ss_n2) break;
    end
    check_val("t5_len", n, 32'd66);
    check_val("t5_period", r2 - r1, 32'd4);
    check_val("t5_rd", {16'd0, rd_data2}, 32'd0);
    check_val("t5_done", {31'd0, done2}, 32'd1);

    // 6: long idle, outputs steady and results retained
    rd0 = rd_data;
    bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (!ss_n || !sclk || !done || rd_data !== rd0) bad++;
    end
    check_val("t6_idle_bad", bad, 32'd0);
    check_val("t6_rd_keep", {16'd0, rd_data}, 32'h0000_0ABC);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

  // global time limit
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
